// File: rtl/miss_ctl.sv
// Miss sequencer for the 4-way, 32B-line L1: victim selection, dirty writeback,
// line fetch, array fill and a one-cycle replay of the stalled access.
module miss_ctl #(
  parameter int unsigned TAG_BITS  = 14,
  parameter int unsigned IDX_BITS  = 13,
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned CNT_BITS  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pe_access,
  input  logic                     pe_req_hit,
  input  logic [TAG_BITS-1:0]      pe_tag,
  input  logic [IDX_BITS-1:0]      pe_index,
  input  logic [3:0]               val_out,
  input  logic [3:0]               mod_out,
  input  logic [2:0]               lru_out,
  input  logic [4*TAG_BITS-1:0]    tag_out_flat,
  input  logic [4*LINE_BITS-1:0]   dary_out_flat,
  output logic                     stall,
  output logic                     replay,
  output logic [3:0]               fill_way,
  output logic [LINE_BITS-1:0]     fill_data,
  output logic [3:0]               tag_write,
  output logic [TAG_BITS-1:0]      tag_wd,
  output logic [3:0]               bit_cmd,
  output logic                     bit_cmd_valid,
  output logic [31:0]              mm_a,
  output logic [LINE_BITS-1:0]     mm_wd,
  output logic                     mm_write,
  output logic                     mm_read,
  input  logic [LINE_BITS-1:0]     mm_rd,
  input  logic                     mm_valid,
  output logic [CNT_BITS-1:0]      miss_count,
  output logic [CNT_BITS-1:0]      wb_count
);

  typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_UPDATE, S_REPLAY} state_t;

  state_t              state;
  logic [TAG_BITS-1:0] req_tag;
  logic [IDX_BITS-1:0] req_index;
  logic [1:0]          vic_way;

  logic                miss;
  logic                found;
  logic [1:0]          pick_way;
  logic                pick_dirty;
  logic [TAG_BITS-1:0] pick_tag;
  logic [LINE_BITS-1:0] pick_line;

  assign miss  = pe_access & ~pe_req_hit;
  assign stall = (state != S_IDLE) | miss;

  // Lowest invalid way wins; with a full set fall back to the pseudo-LRU tree.
  always_comb begin
    pick_way = lru_out[0] ? {1'b1, lru_out[2]} : {1'b0, lru_out[1]};
    found    = 1'b0;
    for (int unsigned w = 0; w < 4; w++) begin
      if (!found && !val_out[w]) begin
        pick_way = 2'(w);
        found    = 1'b1;
      end
    end
    pick_dirty = val_out[pick_way] & mod_out[pick_way];
    pick_tag   = tag_out_flat[int'(pick_way)*TAG_BITS +: TAG_BITS];
    pick_line  = dary_out_flat[int'(pick_way)*LINE_BITS +: LINE_BITS];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      req_tag       <= '0;
      req_index     <= '0;
      vic_way       <= '0;
      replay        <= 1'b0;
      fill_way      <= '0;
      fill_data     <= '0;
      tag_write     <= '0;
      tag_wd        <= '0;
      bit_cmd       <= '0;
      bit_cmd_valid <= 1'b0;
      mm_a          <= '0;
      mm_wd         <= '0;
      mm_write      <= 1'b0;
      mm_read       <= 1'b0;
      miss_count    <= '0;
      wb_count      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (miss) begin
            req_tag    <= pe_tag;
            req_index  <= pe_index;
            vic_way    <= pick_way;
            miss_count <= miss_count + CNT_BITS'(1);
            // The victim tag/line are captured straight into the writeback port.
            if (pick_dirty) begin
              mm_a     <= {pick_tag, pe_index, 5'b0};
              mm_wd    <= pick_line;
              mm_write <= 1'b1;
              wb_count <= wb_count + CNT_BITS'(1);
              state    <= S_WB;
            end else begin
              mm_a    <= {pe_tag, pe_index, 5'b0};
              mm_read <= 1'b1;
              state   <= S_FILL;
            end
          end
        end
        S_WB: begin
          if (mm_valid) begin
            mm_write <= 1'b0;
            mm_read  <= 1'b1;
            mm_a     <= {req_tag, req_index, 5'b0};
            state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (mm_valid) begin
            mm_read       <= 1'b0;
            fill_data     <= mm_rd;
            fill_way      <= 4'b0001 << vic_way;
            tag_write     <= 4'b0001 << vic_way;
            tag_wd        <= req_tag;
            bit_cmd       <= 4'h1;
            bit_cmd_valid <= 1'b1;
            state         <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          fill_way      <= '0;
          tag_write     <= '0;
          bit_cmd       <= '0;
          bit_cmd_valid <= 1'b0;
          replay        <= 1'b1;
          state         <= S_REPLAY;
        end
        S_REPLAY: begin
          replay <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miss_ctl.sv
// Directed bench for miss_ctl: a timestamp-based transaction model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_miss_ctl;

  logic         clk = 1'b0;
  logic         reset;
  logic         pe_access, pe_req_hit;
  logic [13:0]  pe_tag;
  logic [12:0]  pe_index;
  logic [3:0]   val_out, mod_out;
  logic [2:0]   lru_out;
  logic [55:0]  tag_out_flat;
  logic [1023:0] dary_out_flat;
  logic         stall, replay;
  logic [3:0]   fill_way, tag_write, bit_cmd;
  logic [255:0] fill_data, mm_wd, mm_rd;
  logic [13:0]  tag_wd;
  logic         bit_cmd_valid;
  logic [31:0]  mm_a;
  logic         mm_write, mm_read, mm_valid;
  logic [31:0]  miss_count, wb_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  miss_ctl #(.TAG_BITS(14), .IDX_BITS(13), .LINE_BITS(256), .CNT_BITS(32)) dut (
    .clk(clk), .reset(reset), .pe_access(pe_access), .pe_req_hit(pe_req_hit),
    .pe_tag(pe_tag), .pe_index(pe_index), .val_out(val_out), .mod_out(mod_out),
    .lru_out(lru_out), .tag_out_flat(tag_out_flat), .dary_out_flat(dary_out_flat),
    .stall(stall), .replay(replay), .fill_way(fill_way), .fill_data(fill_data),
    .tag_write(tag_write), .tag_wd(tag_wd), .bit_cmd(bit_cmd),
    .bit_cmd_valid(bit_cmd_valid), .mm_a(mm_a), .mm_wd(mm_wd),
    .mm_write(mm_write), .mm_read(mm_read), .mm_rd(mm_rd), .mm_valid(mm_valid),
    .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: timestamps of the miss, writeback completion and fill
  // completion decide every output; edge_n counts rising edges.
  int unsigned edge_n = 0;
  int unsigned f_edge = 0;
  bit          started = 0, busy = 0, wb_pend = 0, fill_done = 0;
  logic [1:0]  m_way;
  logic [13:0] m_tag, m_vtag;
  logic [12:0] m_idx;
  logic [255:0] m_vline, m_fill;
  int unsigned m_miss = 0, m_wb = 0;

  function automatic logic [1:0] pick_victim(input logic [3:0] v, input logic [2:0] l);
    for (int w = 0; w < 4; w++)
      if (!v[w]) return 2'(w);
    if (l[0] == 1'b0) return l[1] ? 2'd1 : 2'd0;
    return l[2] ? 2'd3 : 2'd2;
  endfunction

  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      started = 1; busy = 0; wb_pend = 0; fill_done = 0; m_miss = 0; m_wb = 0;
    end else if (!busy) begin
      if (pe_access && !pe_req_hit) begin
        busy      = 1;
        fill_done = 0;
        m_tag     = pe_tag;
        m_idx     = pe_index;
        m_way     = pick_victim(val_out, lru_out);
        m_vtag    = tag_out_flat[int'(m_way)*14 +: 14];
        m_vline   = dary_out_flat[int'(m_way)*256 +: 256];
        wb_pend   = val_out[m_way] && mod_out[m_way];
        m_miss++;
        if (wb_pend) m_wb++;
      end
    end else if (wb_pend) begin
      if (mm_valid) wb_pend = 0;
    end else if (!fill_done) begin
      if (mm_valid) begin
        fill_done = 1;
        f_edge    = edge_n;
        m_fill    = mm_rd;
      end
    end else if (edge_n == f_edge + 2) begin
      busy = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      bit e_write, e_read, e_upd, e_rep;
      e_write = busy && wb_pend;
      e_read  = busy && !wb_pend && !fill_done;
      e_upd   = busy && fill_done && edge_n == f_edge;
      e_rep   = busy && fill_done && edge_n == f_edge + 1;
      check("stall", stall, busy || (pe_access && !pe_req_hit));
      check("mm_write", mm_write, e_write);
      check("mm_read", mm_read, e_read);
      check("mm_overlap", mm_read & mm_write, 0);
      if (e_write) begin
        check("mm_a_wb", mm_a, {m_vtag, m_idx, 5'b0});
        check("mm_wd", mm_wd, m_vline);
      end
      if (e_read) check("mm_a_fill", mm_a, {m_tag, m_idx, 5'b0});
      check("fill_way", fill_way, e_upd ? (4'b0001 << m_way) : 4'b0000);
      check("tag_write", tag_write, e_upd ? (4'b0001 << m_way) : 4'b0000);
      check("bit_cmd_valid", bit_cmd_valid, e_upd);
      if (e_upd) begin
        check("bit_cmd", bit_cmd, 4'h1);
        check("tag_wd", tag_wd, m_tag);
        check("fill_data", fill_data, m_fill);
      end
      check("replay", replay, e_rep);
      check("miss_count", miss_count, m_miss);
      check("wb_count", wb_count, m_wb);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50; i++) begin
      if (mm_read || mm_write) break;
      tick();
    end
    check("mm_req_timeout", mm_read | mm_write, 1);
  endtask

  // Answer the pending mm request after lat cycles; returns just after the
  // completing edge.
  task automatic mem_cycle(input int lat, input logic [255:0] data);
    wait_req();
    tick(lat - 1);
    mm_valid = 1'b1;
    mm_rd    = data;
    tick();
    mm_valid = 1'b0;
  endtask

  task automatic present_miss(input logic [13:0] t, input logic [12:0] idx,
                              input logic [3:0] v, input logic [3:0] m, input logic [2:0] l);
    pe_access  = 1'b1;
    pe_req_hit = 1'b0;
    pe_tag     = t;
    pe_index   = idx;
    val_out    = v;
    mod_out    = m;
    lru_out    = l;
  endtask

  initial begin
    reset = 1'b1; pe_access = 1'b0; pe_req_hit = 1'b0; pe_tag = '0; pe_index = '0;
    val_out = '0; mod_out = '0; lru_out = '0; mm_valid = 1'b0; mm_rd = '0;
    for (int w = 0; w < 4; w++) begin
      tag_out_flat[w*14 +: 14]    = 14'h100 + 14'(w);
      dary_out_flat[w*256 +: 256] = {8{32'hA000_0000 + 32'(w)}};
    end
    tick(3);
    reset = 1'b0;
    check("rst_stall", stall, 0);
    check("rst_mm_a", mm_a, 32'h0);
    check("rst_miss_count", miss_count, 0);
    check("rst_fill_way", fill_way, 4'b0000);

    // Cold miss to 0x0004_0020: tag 1, index 1, empty set.
    present_miss(14'h0001, 13'h0001, 4'b0000, 4'b0000, 3'b000);
    #1 check("cold_stall_comb", stall, 1);
    tick();
    pe_access = 1'b0;
    check("cold_mm_read", mm_read, 1);
    check("cold_mm_a", mm_a, 32'h0004_0020);
    mem_cycle(3, {8{32'h1234_5678}});
    check("cold_fill_way", fill_way, 4'b0001);
    check("cold_tag_wd", tag_wd, 14'h0001);
    check("cold_fill_data", fill_data, {8{32'h1234_5678}});
    tick();
    check("cold_replay", replay, 1);
    check("cold_miss_count", miss_count, 1);
    tick();
    check("cold_stall_done", stall, 0);

    // Dirty eviction of way 2.
    present_miss(14'h02AB, 13'd5, 4'hF, 4'b0100, 3'b001);
    tick();
    pe_access = 1'b0;
    check("dirty_mm_write", mm_write, 1);
    check("dirty_mm_a", mm_a, {14'h102, 13'd5, 5'b0});
    check("dirty_mm_wd", mm_wd, {8{32'hA000_0002}});
    check("dirty_wb_count", wb_count, 1);
    mem_cycle(2, '0);
    check("dirty_then_read", mm_read, 1);
    check("dirty_write_drop", mm_write, 0);
    check("dirty_read_a", mm_a, {14'h02AB, 13'd5, 5'b0});
    mem_cycle(2, {8{32'hBEEF_0002}});
    check("dirty_fill_way", fill_way, 4'b0100);
    tick(2);

    // Clean full set, LRU selects way 3.
    present_miss(14'h3FFF, 13'd7, 4'hF, 4'b0000, 3'b101);
    tick();
    pe_access = 1'b0;
    check("clean_no_write", mm_write, 0);
    mem_cycle(1, {8{32'hC1EA_0003}});
    check("clean_fill_way", fill_way, 4'b1000);
    check("clean_wb_count", wb_count, 1);
    tick(2);

    // Invalid way 2 beats the LRU and is never written back despite its mod bit.
    present_miss(14'h0042, 13'd9, 4'b1011, 4'b1111, 3'b000);
    tick();
    pe_access = 1'b0;
    check("inv_no_write", mm_write, 0);
    mem_cycle(2, {8{32'h0000_0042}});
    check("inv_fill_way", fill_way, 4'b0100);
    tick(2);

    // Hit with a spurious mm_valid in IDLE.
    pe_access = 1'b1; pe_req_hit = 1'b1; mm_valid = 1'b1;
    tick();
    mm_valid = 1'b0;
    check("hit_stall", stall, 0);
    check("hit_no_read", mm_read, 0);
    check("hit_miss_count", miss_count, 4);
    tick();
    pe_access = 1'b0; pe_req_hit = 1'b0;

    // Reset while the fill request is outstanding.
    present_miss(14'h0010, 13'd3, 4'b0000, 4'b0000, 3'b000);
    tick();
    pe_access = 1'b0;
    tick(2);
    check("pre_rst_read", mm_read, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_read", mm_read, 0);
    check("midrst_stall", stall, 0);
    check("midrst_miss_count", miss_count, 0);
    check("midrst_wb_count", wb_count, 0);
    mm_valid = 1'b1;
    tick();
    mm_valid = 1'b0;
    check("midrst_late_valid", fill_way, 4'b0000);

    // Back-to-back misses, memory latency 5; the second waits out the replay.
    present_miss(14'h0020, 13'd10, 4'b0000, 4'b0000, 3'b000);
    tick();
    pe_index = 13'd11;
    pe_tag   = 14'h0021;
    mem_cycle(5, {8{32'hAAAA_000A}});
    check("b2b_hold_count", miss_count, 1);
    mem_cycle(5, {8{32'hBBBB_000B}});
    pe_access = 1'b0;
    check("b2b_second_way", fill_way, 4'b0001);
    check("b2b_tag_wd", tag_wd, 14'h0021);
    tick(3);
    check("b2b_miss_count", miss_count, 2);
    check("b2b_idle", stall, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
